// File: rtl/ycrcb_pkg.sv
// ycrcb_pkg: shared byte width, default line-count width and 4:2:2 phase enum
package ycrcb_pkg;
  localparam int BW = 8;
  localparam int XW_DEF = 10;
  typedef enum logic [1:0] {C0, Y0, C1, Y1} phase_e;
endpackage

// File: rtl/ycrcb422_unpack.sv
// ycrcb422_unpack: interleaved 4:2:2 byte stream to one y/cr/cb triplet per pixel
module ycrcb422_unpack
  import ycrcb_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter bit CB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] din,
  input  logic          din_valid,
  input  logic          din_sol,
  output logic [BW-1:0] y,
  output logic [BW-1:0] cr,
  output logic [BW-1:0] cb,
  output logic          pix_valid,
  output logic          pix_sol,
  output logic [XW-1:0] hcount,
  output logic          sync_err
);
  phase_e phase, phase_nx, eff;
  logic [BW-1:0] c0_q, c1_q, y0_q, c1v, y_nx, cb_nx, cr_nx;
  logic [XW-1:0] cnt;
  logic started, pend, emit;
  always_ff @(posedge clk) phase <= !rst_n ? C0 : phase_nx;
  // a start-of-line byte is always the first chroma byte, whatever the phase
  always_comb begin
    eff = din_sol ? C0 : phase;
    phase_nx = !din_valid ? phase : eff == C0 ? Y0 : eff == Y0 ? C1 : eff == C1 ? Y1 : C0;
  end
  always_comb begin
    emit = din_valid && started && (eff == C1 || eff == Y1);
    c1v = eff == C1 ? din : c1_q;
    y_nx = eff == C1 ? y0_q : din;
    cb_nx = CB_FIRST ? c0_q : c1v;
    cr_nx = CB_FIRST ? c1v : c0_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= '0;
      cr <= '0;
      cb <= '0;
      pix_valid <= 1'b0;
      pix_sol <= 1'b0;
      hcount <= '0;
      sync_err <= 1'b0;
      c0_q <= '0;
      c1_q <= '0;
      y0_q <= '0;
      cnt <= '0;
      started <= 1'b0;
      pend <= 1'b0;
    end else begin
      pix_valid <= emit;
      pix_sol <= emit && pend;
      sync_err <= din_valid && din_sol && phase != C0;
      if (din_valid) begin
        if (din_sol) begin
          started <= 1'b1;
          pend <= 1'b1;
          cnt <= '0;
        end
        if (eff == C0) c0_q <= din;
        if (eff == Y0) y0_q <= din;
        if (eff == C1) c1_q <= din;
      end
      if (emit) begin
        y <= y_nx;
        cb <= cb_nx;
        cr <= cr_nx;
        hcount <= cnt;
        cnt <= &cnt ? cnt : cnt + 1'b1;
        pend <= 1'b0;
      end
    end
  end
endmodule
